fpu_cvt_arb: RTL
================

FPU_CVT_ARB -- requirements
Module: fpu_cvt_arb

Interface
REQ-001 Parameter TAG_W, default 5: width of the destination tag carried with each request.
REQ-002 Parameter NREQ, fixed 2: number of requesters.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  kill all in-flight work (mispredict/exception squash).
REQ-006 frm  input  3  dynamic rounding mode from the CSR file.
REQ-007 req_valid  input  NREQ  per-requester request valid.
REQ-008 req_ready  output  NREQ  per-requester accept; the transfer occurs when valid&&ready.
REQ-009 req_op  input  NREQ×32  float operand bits, one per requester.
REQ-010 req_signed  input  NREQ  signed (1) or unsigned (0) integer target.
REQ-011 req_rm  input  NREQ×3  instruction rounding mode; 3'b111 means dynamic.
REQ-012 req_tag  input  NREQ×TAG_W  destination tag.
REQ-013 out_valid  output  1  result register holds a valid result.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_data  output  32  converted integer.
REQ-016 out_tag  output  TAG_W  tag of the result.
REQ-017 out_src  output  1  index of the requester that issued the result.
REQ-018 out_illegal  output  1  the effective rounding mode was illegal; out_data is 0.

Function
REQ-019 Effective rm: req_rm when it is not 3'b111, otherwise frm; legal values are 000–100 only (RNE, RTZ, RDN, RUP, RMM).
REQ-020 A single shared combinational float-to-int converter is driven by the granted requester's op, signed flag and effective rm.
REQ-021 Arbitration is round-robin with a 1-bit priority pointer, reset to 0 (requester 0 preferred).
REQ-022 When both requesters are valid, the grant goes to the pointer; after any accepted transfer the pointer becomes the complement of the granted index.
REQ-023 When exactly one requester is valid, it is granted regardless of the pointer, and the pointer still updates per REQ-022.
REQ-024 can_issue = !out_valid || out_ready; req_ready[i] = can_issue && grant[i] && !flush; at most one req_ready bit is high in any cycle.
REQ-025 Latency is exactly 1 cycle: the result is captured in the output register on the accept edge, and out_valid is high from the next cycle.
REQ-026 The result is held stable (data, tag, src, illegal) while out_valid && !out_ready.
REQ-027 With out_ready held high, throughput is one conversion per cycle (back-to-back); drain and refill may occur in the same cycle.
REQ-028 Illegal effective rm: the request is still accepted, with out_illegal=1 and out_data=32'h0.
REQ-029 out_data is 0, out_tag 0, out_src 0 and out_illegal 0 whenever out_valid is 0.
REQ-030 flush: out_valid is cleared on the next edge, no request is accepted in the flush cycle, and the pointer is unchanged.
REQ-031 flush and out_ready in the same cycle: the result is considered dropped, not delivered, and the consumer must ignore it.
REQ-032 Converter semantics, within the shared unit: saturate on overflow, give 0 for negative to unsigned, and suppress round-up when the magnitude is all ones.

Reset
REQ-033 On reset, out_valid=0, the pointer=0, all output registers are 0 and req_ready=0 in the reset cycle.
REQ-034 Reset dominates flush and any handshake in the same cycle.
REQ-035 Asserting reset while a result is pending discards it with no output.

Structure
REQ-036 fpu_pkg holds the rounding-mode constants (RNE, RTZ, RDN, RUP, RMM, DYN=3'b111) and a cvt_req_t struct {op, is_signed, rm, tag}.
REQ-037 The block instantiates exactly one fpu_flt2int sub-module; arbitration, rm resolution and the output register are local to it.
REQ-038 No other state is kept beyond the output register and the priority pointer.

Verification
REQ-039 Req0 op=0x3FC00000 (1.5), signed, rm=RNE, out_ready=1 -> next cycle out_valid=1, out_data=2, out_src=0.
REQ-040 Both requesters valid for 4 cycles, op0=0x40200000 (2.5, RNE), op1=0x40400000 (3.0) -> grants go 0,1,0,1 and outputs are 2,3,2,3.
REQ-041 out_ready=0 for 3 cycles with a result pending -> req_ready=0 and out_* stable; when out_ready rises, the next request is accepted in that same cycle.
REQ-042 Req1 op=0xBFC00000 (-1.5), signed, rm=3'b111, frm=RTZ -> out_data=0xFFFFFFFF; with frm=3'b101 -> out_illegal=1, out_data=0.
REQ-043 flush asserted while out_valid=1 and req0 valid -> out_valid=0 next cycle, no accept, pointer unchanged.
REQ-044 Reset asserted mid-stream -> all outputs 0 next cycle and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the float-to-int conversion slice: rounding-mode
// encodings, the request record handed to the shared converter, and small
// helpers for resolving the dynamic rounding mode.
package fpu_pkg;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  // Width of the tag field in the request record; the arbiter's TAG_W
  // must not exceed it.
  localparam int CVT_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          op;
    logic                 is_signed;
    logic [2:0]           rm;
    logic [CVT_TAG_W-1:0] tag;
  } cvt_req_t;

  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == DYN) ? frm : rm;
  endfunction

  function automatic logic rm_illegal(input logic [2:0] rm);
    return rm > RMM;
  endfunction

endpackage

// File: rtl/fpu_flt2int.sv
// Combinational single-precision float to 32-bit integer converter.
//   op        : IEEE-754 binary32 operand
//   is_signed : 1 = int32 target, 0 = uint32 target
//   rm        : resolved rounding mode (RNE/RTZ/RDN/RUP/RMM; others truncate)
//   res       : converted integer, saturated on overflow; NaN converts as a
//               positive overflow; negative values to unsigned give 0.
module fpu_flt2int
  import fpu_pkg::*;
(
  input  logic [31:0] op,
  input  logic        is_signed,
  input  logic [2:0]  rm,
  output logic [31:0] res
);

  function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                    input logic lsb, input logic rbit, input logic sticky);
    case (mode)
      RNE:     return rbit && (sticky || lsb);
      RTZ:     return 1'b0;
      RDN:     return sign && (rbit || sticky);
      RUP:     return !sign && (rbit || sticky);
      RMM:     return rbit;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] saturate(input logic sign, input logic sgn_tgt,
                                           input logic ovf, input logic [31:0] mag);
    if (!sgn_tgt) begin
      if (sign) return 32'h0;
      return ovf ? 32'hFFFF_FFFF : mag;
    end
    if (ovf) return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (!sign) return mag[31] ? 32'h7FFF_FFFF : mag;
    return (mag > 32'h8000_0000) ? 32'h8000_0000 : (32'h0 - mag);
  endfunction

  logic [7:0]  exp_f;
  logic [23:0] sig;
  logic        is_nan;
  logic        sign;
  logic        ovf;
  logic        tiny;
  logic [5:0]  shamt;
  logic [63:0] fixed;
  logic [31:0] intp;
  logic        rbit;
  logic        sticky;
  logic        rup;
  logic [31:0] mag;

  always_comb begin
    exp_f  = op[30:23];
    sig    = {|exp_f, op[22:0]};
    is_nan = (exp_f == 8'hFF) && (op[22:0] != 23'h0);
    sign   = op[31] && !is_nan;
    // Magnitude >= 2^32 (including Inf/NaN) overflows any 32-bit target.
    ovf    = exp_f >= 8'd159;
    // Magnitude < 0.5: integer part and round bit are zero, only sticky survives.
    tiny   = exp_f < 8'd126;
    // Fixed point with 32 integer and 32 fraction bits; the hidden bit sits at
    // bit 63 before shifting, so shifts of 0..32 never lose bits.
    shamt  = 6'(8'd158 - exp_f);
    fixed  = {sig, 40'h0} >> shamt;
    intp   = tiny ? 32'h0 : fixed[63:32];
    rbit   = tiny ? 1'b0 : fixed[31];
    sticky = tiny ? (|op[30:0]) : (|fixed[30:0]);
    // An all-ones magnitude must not wrap to zero when rounding up.
    rup    = round_up(rm, sign, intp[0], rbit, sticky) && (intp != 32'hFFFF_FFFF);
    mag    = intp + 32'(rup);
    res    = saturate(sign, is_signed, ovf, mag);
  end

endmodule

// File: rtl/fpu_cvt_arb.sv
// Two-requester round-robin front end for a shared float-to-int converter.
//   clock, reset   : single clock, synchronous active-high reset
//   flush          : squash the pending result and refuse requests this cycle
//   frm            : dynamic rounding mode used when a request's rm is DYN
//   req_*          : per-requester valid/ready handshake and payload
//   out_*          : one-entry result register with valid/ready handshake;
//                    out_src names the requester, out_illegal flags an illegal
//                    effective rounding mode (out_data is then 0)
// All out_* payload reads as 0 while out_valid is low.
module fpu_cvt_arb
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int NREQ  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [2:0]                 frm,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][31:0]      req_op,
  input  logic [NREQ-1:0]            req_signed,
  input  logic [NREQ-1:0][2:0]       req_rm,
  input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_src,
  output logic                       out_illegal
);

  logic             vld_p0;
  logic             ptr_p0;
  logic [31:0]      data_p0;
  logic [TAG_W-1:0] tag_p0;
  logic             src_p0;
  logic             ill_p0;

  logic             gnt;
  logic             can_issue;
  logic             accept;
  cvt_req_t         sel;
  logic [2:0]       eff_rm;
  logic             illegal;
  logic [31:0]      cvt_res;

  always_comb begin
    // With both valid the pointer decides; otherwise the lone requester wins.
    gnt            = (&req_valid) ? ptr_p0 : req_valid[1];
    can_issue      = !vld_p0 || out_ready;
    accept         = (|req_valid) && can_issue && !flush && !reset;
    req_ready      = '0;
    req_ready[gnt] = accept;
    sel.op         = req_op[gnt];
    sel.is_signed  = req_signed[gnt];
    sel.rm         = req_rm[gnt];
    sel.tag        = CVT_TAG_W'(req_tag[gnt]);
    eff_rm         = resolve_rm(sel.rm, frm);
    illegal        = rm_illegal(eff_rm);
  end

  fpu_flt2int u_cvt (
    .op        (sel.op),
    .is_signed (sel.is_signed),
    .rm        (eff_rm),
    .res       (cvt_res)
  );

  // Stage p0: result register and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      ptr_p0 <= 1'b0;
    end else begin
      if (flush)          vld_p0 <= 1'b0;
      else if (accept)    vld_p0 <= 1'b1;
      else if (out_ready) vld_p0 <= 1'b0;
      if (accept) ptr_p0 <= ~gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      data_p0 <= illegal ? 32'h0 : cvt_res;
      tag_p0  <= sel.tag[TAG_W-1:0];
      src_p0  <= gnt;
      ill_p0  <= illegal;
    end
  end

  assign out_valid   = vld_p0;
  assign out_data    = vld_p0 ? data_p0 : 32'h0;
  assign out_tag     = vld_p0 ? tag_p0 : '0;
  assign out_src     = vld_p0 && src_p0;
  assign out_illegal = vld_p0 && ill_p0;

endmodule
